// File: rtl/dmem_responder_if.sv
// Load/store bus between the CPU (master) and the data-memory responder (slave).
// Both channels: a transfer happens on a rising edge where valid && ready; once valid is high
// its payload stays stable and valid stays high until that edge.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait states, then a response.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned requests return rsp_err=1 and leave memory untouched.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               startin,
    dmem_responder_if.slave    bus,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [31:0]          mem [DEPTH_WORDS];
    logic                 rsp_valid_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_err_q;
    logic [ADDR_BITS-1:0] idx;
    logic                 accept;
    logic                 misaligned;
    logic                 unused_addr;

    assign idx         = bus.req_addr[ADDR_BITS+1:2];
    assign accept      = (state == S_IDLE) && bus.req_valid;
    assign unused_addr = ^{bus.req_addr[31:ADDR_BITS+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |bus.req_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Load data is the pre-write word; stores and rejected accesses return 0.
                        rsp_rdata_q <= (bus.req_write || misaligned) ? '0 : mem[idx];
                        rsp_err_q   <= misaligned;
                        if (WAIT_CYCLES == 0) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stores commit at the accept edge, one byte lane per enable bit.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (accept && bus.req_write && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of {rsp_err, rsp_rdata} per accepted request.
// Instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0 (zero-wait latency).
module tb_dmem_responder;

  logic clk = 1'b0;
  logic startin = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();
  logic [1:0] state_dbg;
  logic [1:0] state_dbg0;

  dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .startin(startin), .bus(bus.slave), .state_dbg(state_dbg)
  );

  dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .startin(startin), .bus(bus0.slave), .state_dbg(state_dbg0)
  );

  int tests_run = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  // ---------------- driver tasks (all start and end at a negedge) ----------------
  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [32:0] exp);
    int n;
    n = 0;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus.req_ready);
    end else begin
      exp_q.push_back(exp);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic recv_rsp(input int delay, input int exp_lat, input string name);
    int lat;
    logic [31:0] held;
    logic [32:0] exp;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      tests_run++;
      if (bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_busy_ready req_ready=%b required 0", name, bus.req_ready);
      end
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== exp_lat || bus.rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_latency got %0d cycles (rsp_valid=%b) required %0d", name, lat, bus.rsp_valid, exp_lat);
      return;
    end
    held = bus.rsp_rdata;
    repeat (delay) begin
      @(negedge clk);
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_hold valid=%b rdata=%h ready=%b required 1/%h/0", name,
                 bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held);
      end
    end
    bus.rsp_ready = 1'b1;
    tests_run++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_unexpected got %h with empty queue", name, {bus.rsp_err, bus.rsp_rdata});
    end else begin
      exp = exp_q.pop_front();
      if ({bus.rsp_err, bus.rsp_rdata} !== exp) begin
        fails++;
        $display("FAIL %s_data got err/rdata=%h required %h", name, {bus.rsp_err, bus.rsp_rdata}, exp);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_release valid=%b ready=%b required 0/1", name, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic do_reset();
    startin = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    startin = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    startin = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 ||
        state_dbg !== 2'd0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state valid=%b rdata=%h err=%b state=%0d ready=%b required 0/0/0/0/1",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, state_dbg, bus.req_ready);
    end
    startin = 1'b1;
    send_req(1'b0, 32'h10, 32'h0, 4'h0, 33'h0);
    recv_rsp(0, 3, "reset_load");
  endtask

  task automatic test_byte_enable();
    send_req(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 33'h0);
    recv_rsp(0, 3, "be_store_full");
    send_req(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 33'h0);
    recv_rsp(1, 3, "be_store_partial");
    send_req(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hDE22_BE44});
    recv_rsp(0, 3, "be_load");
    send_req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 33'h0);
    recv_rsp(0, 3, "be_store_none");
    send_req(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hDE22_BE44});
    recv_rsp(0, 3, "be_load_unchanged");
  endtask

  task automatic test_backpressure();
    send_req(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hDE22_BE44});
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'h0BAD_F00D;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    recv_rsp(5, 3, "bp_load");
    send_req(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, 33'h0);
    recv_rsp(0, 3, "bp_store");
    send_req(1'b0, 32'h24, 32'h0, 4'h0, {1'b0, 32'h0BAD_F00D});
    recv_rsp(0, 3, "bp_load_back");
  endtask

  task automatic test_wrap();
    send_req(1'b1, 32'h0000_0400, 32'hCAFE_0001, 4'hF, 33'h0);
    recv_rsp(0, 3, "wrap_store");
    send_req(1'b0, 32'h0, 32'h0, 4'h0, {1'b0, 32'hCAFE_0001});
    recv_rsp(0, 3, "wrap_load");
  endtask

  task automatic test_align();
`ifdef DMEM_ALIGN_CHECK_EN
    send_req(1'b1, 32'h42, 32'hFFFF_FFFF, 4'hF, {1'b1, 32'h0});
    recv_rsp(0, 3, "align_store");
    send_req(1'b0, 32'h40, 32'h0, 4'h0, {1'b0, 32'h0});
    recv_rsp(0, 3, "align_load");
`else
    send_req(1'b1, 32'h42, 32'hFFFF_FFFF, 4'hF, {1'b0, 32'h0});
    recv_rsp(0, 3, "align_store");
    send_req(1'b0, 32'h40, 32'h0, 4'h0, {1'b0, 32'hFFFF_FFFF});
    recv_rsp(0, 3, "align_load");
`endif
  endtask

  task automatic test_mid_reset();
    send_req(1'b1, 32'h30, 32'h5555_5555, 4'hF, 33'h0);
    startin = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL midreset_drop valid=%b state=%0d required 0/0", bus.rsp_valid, state_dbg);
    end
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (bus.rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL midreset_valid valid=%b required 0", bus.rsp_valid);
      end
    end
    startin = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (bus.rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL midreset_ghost valid=%b required 0", bus.rsp_valid);
      end
    end
    send_req(1'b0, 32'h30, 32'h0, 4'h0, 33'h0);
    recv_rsp(0, 3, "midreset_load30");
    send_req(1'b0, 32'h20, 32'h0, 4'h0, 33'h0);
    recv_rsp(0, 3, "midreset_load20");
  endtask

  task automatic test_zero_wait();
    logic        wr_t[3]   = '{1'b0, 1'b1, 1'b0};
    logic [31:0] addr_t[3] = '{32'h10, 32'h8, 32'h8};
    logic [31:0] data_t[3] = '{32'h0, 32'h1234_5678, 32'h0};
    logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      bus0.req_write = wr_t[i];
      bus0.req_addr  = addr_t[i];
      bus0.req_wdata = data_t[i];
      bus0.req_be    = 4'hF;
      bus0.req_valid = 1'b1;
      tests_run++;
      if (bus0.req_ready !== 1'b1) begin
        fails++;
        $display("FAIL zw_ready_%0d ready=%b required 1", i, bus0.req_ready);
      end
      exp_q.push_back((i == 2) ? {1'b0, 32'h1234_5678} : 33'h0);
      @(negedge clk);
      bus0.req_valid = 1'b0;
      bus0.rsp_ready = 1'b1;
      exp = exp_q.pop_front();
      tests_run++;
      if (bus0.rsp_valid !== 1'b1 || {bus0.rsp_err, bus0.rsp_rdata} !== exp || bus0.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL zw_rsp_%0d valid=%b data=%h ready=%b required 1/%h/0", i,
                 bus0.rsp_valid, {bus0.rsp_err, bus0.rsp_rdata}, bus0.req_ready, exp);
      end
      @(negedge clk);
      bus0.rsp_ready = 1'b0;
      tests_run++;
      if (bus0.rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL zw_release_%0d valid=%b required 0", i, bus0.rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] mdl[16];
    logic [31:0] addr, wdata, word;
    logic [3:0]  be;
    logic        wr;
    int          w;
    do_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    for (int t = 0; t < 24; t++) begin
      w     = $urandom_range(0, 15);
      addr  = (32'($urandom_range(0, 7)) << 10) | (32'(w) << 2);
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      if (wr) begin
        word = mdl[w];
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        mdl[w] = word;
        send_req(1'b1, addr, wdata, be, 33'h0);
      end else begin
        send_req(1'b0, addr, wdata, be, {1'b0, mdl[w]});
      end
      recv_rsp($urandom_range(0, 2), 3, "random");
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;      bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0;   bus0.req_be = '0;      bus0.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_byte_enable();
    test_backpressure();
    test_wrap();
    test_align();
    test_mid_reset();
    test_zero_wait();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's load/store interface.
- Accepts one word request at a time over a valid/ready request channel.
- Inserts a parameterised number of wait states, then returns a response on a valid/ready response channel.
- Backs the multi-cycle CPU variant, replacing the zero-latency data memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- ADDR_BITS, 8, log2(DEPTH_WORDS); word index = req_addr[ADDR_BITS+1:2].
- WAIT_CYCLES, 2, wait states between request acceptance and response valid; 0 is legal.

Ports:
- clk  input  1  rising-edge clock
- startin  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i = byte lane [8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  load data; 0 for stores
- rsp_err  output  1  error response (see Optional Feature)

Behaviour:
- Reset (startin=0, async):
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory words cleared to 0.
  - Any in-flight transaction is dropped with no response.
- req_ready = (state==IDLE), a combinational decode of registered state. No other output is combinational on inputs.
- States:
  - IDLE: on req_valid=1 (accept edge N):
    - Store: write lanes with req_be=1; lanes with req_be=0 keep old value. Latch rsp_rdata=0.
    - Load: latch rsp_rdata=mem[idx] (pre-write value).
    - If WAIT_CYCLES=0, go to RESP; else go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: each edge, if counter==0 go to RESP, else decrement. Inputs are ignored.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. On the handshake edge go to IDLE; rsp_valid drops and req_ready rises in the following cycle.
- Latency:
  - Accept at edge N gives rsp_valid high in the cycle after edge N+WAIT_CYCLES.
  - Minimum occupancy is WAIT_CYCLES+2 cycles per transaction. No overlap: a request is never accepted in the same cycle as a response handshake.
- Addressing:
  - Upper address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Example: with defaults, 0x0000_0400 aliases word 0.
- req_be=4'b0000 on a store: no memory change; a normal response is still returned.
- req_* values while req_ready=0 are don't-care and never sampled.
- rsp_valid never deasserts without a handshake (except reset). rsp_ready while rsp_valid=0 has no effect.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0]!=2'b00 is still accepted and timed identically.
  - The memory is not written.
  - Response carries rsp_err=1 and rsp_rdata=0.
  - Aligned requests give rsp_err=0.
- Undefined:
  - req_addr[1:0] is ignored; the access proceeds to word idx.
  - rsp_err is tied to 0.

Test Plan:
- Reset then load: hold startin=0 for 2 cycles, release. Load addr 0x10 -> rsp_rdata=0x0000_0000. rsp_valid first high exactly 3 cycles after the accept edge (WAIT_CYCLES=2). req_ready=0 throughout.
- Store/load with byte enables: store 0xDEAD_BEEF to 0x20 be=4'hF, then store 0x1122_3344 to 0x20 be=4'b0101. Load 0x20 -> 0xDE22_BE44. Store responses carry rsp_rdata=0.
- Response backpressure: load 0x20 with rsp_ready=0 for 5 cycles. rsp_valid stays 1 and rsp_rdata stays constant; req_valid=1 with a new store to 0x24 is not accepted. Raise rsp_ready: IDLE next cycle, then the store is accepted.
- Address wrap: store 0xCAFE_0001 to 0x0000_0400, then load 0x0. Response is 0xCAFE_0001 (DEPTH_WORDS=256).
- Reset mid-operation: accept a store of 0x5555_5555 to 0x30. Assert startin=0 during WAIT. rsp_valid drops immediately and never asserts for that request; a subsequent load of 0x30 returns 0. Also repeat the first scenario with WAIT_CYCLES=0: response valid in the cycle after accept.
- With DMEM_ALIGN_CHECK_EN: store 0xFFFF_FFFF to 0x42 -> rsp_err=1, rsp_rdata=0. Load 0x40 -> 0, rsp_err=0. Without the macro, the same store writes word 0x40 and rsp_err=0.
